// File: rtl/fifo_rd_framer.sv
// Read-side FIFO consumer: pops words into a 2-entry skid buffer and presents them
// as a valid/ready stream, tagging every PKT_LEN-th accepted beat as last.
module fifo_rd_framer #(
  parameter int DSIZE   = 8,
  parameter int PKT_LEN = 4,
  parameter int CW      = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] fifo_rdata,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [CW-1:0]    frame_cnt
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  typedef enum logic {HOLD, RUN} state_t;

  state_t           state;
  logic [1:0]       cnt;
  logic [DSIZE-1:0] slot0;
  logic [DSIZE-1:0] slot1;
  logic [BW-1:0]    beat_cnt;
  logic             push;
  logic             pop;

  // Pop decision looks only at registered occupancy, so out_ready never reaches fifo_rinc.
  assign fifo_rinc = (state == RUN) && !fifo_rempty && (cnt < 2'd2);
  assign push      = fifo_rinc;
  assign pop       = out_valid && out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = slot0;
  assign out_last  = out_valid && (beat_cnt == LAST_BEAT);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state     <= HOLD;
      cnt       <= 2'd0;
      slot0     <= '0;
      slot1     <= '0;
      beat_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      if (state == HOLD) state <= RUN;

      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= fifo_rdata;
          else             slot1 <= fifo_rdata;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        // Simultaneous push/pop only happens with cnt=1: the new word replaces the head.
        2'b11:   slot0 <= fifo_rdata;
        default: ;
      endcase

      if (pop) begin
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt  <= '0;
          frame_cnt <= frame_cnt + CW'(1);
        end else begin
          beat_cnt  <= beat_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Bench for fifo_rd_framer: three instances (default, CW=2, PKT_LEN=1) each fed
// by a simple FIFO model with a combinational head word.
module tb_fifo_rd_framer;

  logic       clk = 1'b0;
  logic       rrst_n = 1'b0;
  logic [7:0] rdata [3];
  logic       rempty [3];
  logic       rinc [3];
  logic [7:0] data [3];
  logic       valid [3];
  logic       last [3];
  logic       ready [3];
  logic [15:0] fc0;
  logic [1:0]  fc1;
  logic [15:0] fc2;

  logic [7:0] mem [3][64];
  int         wp [3];
  int         rp [3];

  int checks = 0;
  int failures = 0;

  logic [7:0]  got_d [64];
  logic        got_l [64];
  logic [15:0] got_fc [64];
  int          got_n;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    assign rempty[g] = (wp[g] == rp[g]);
    assign rdata[g]  = mem[g][rp[g] % 64];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (rinc[i]) rp[i] <= rp[i] + 1;
  end

  fifo_rd_framer #(.DSIZE(8), .PKT_LEN(4), .CW(16)) dut0 (
    .rclk(clk), .rrst_n(rrst_n), .fifo_rdata(rdata[0]), .fifo_rempty(rempty[0]),
    .fifo_rinc(rinc[0]), .out_data(data[0]), .out_valid(valid[0]), .out_last(last[0]),
    .out_ready(ready[0]), .frame_cnt(fc0));

  fifo_rd_framer #(.DSIZE(8), .PKT_LEN(4), .CW(2)) dut1 (
    .rclk(clk), .rrst_n(rrst_n), .fifo_rdata(rdata[1]), .fifo_rempty(rempty[1]),
    .fifo_rinc(rinc[1]), .out_data(data[1]), .out_valid(valid[1]), .out_last(last[1]),
    .out_ready(ready[1]), .frame_cnt(fc1));

  fifo_rd_framer #(.DSIZE(8), .PKT_LEN(1), .CW(16)) dut2 (
    .rclk(clk), .rrst_n(rrst_n), .fifo_rdata(rdata[2]), .fifo_rempty(rempty[2]),
    .fifo_rinc(rinc[2]), .out_data(data[2]), .out_valid(valid[2]), .out_last(last[2]),
    .out_ready(ready[2]), .frame_cnt(fc2));

  typedef struct {
    logic        ready;
    logic        rinc;
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int f, input logic [7:0] d);
    mem[f][wp[f] % 64] = d;
    wp[f] = wp[f] + 1;
  endtask

  function automatic logic [15:0] fcv(input int f);
    case (f)
      0:       return fc0;
      1:       return {14'd0, fc1};
      default: return fc2;
    endcase
  endfunction

  // Call right after driving inputs at a falling edge; samples each cycle, returns at a falling edge.
  task automatic collect(input int f, input int n, input int budget);
    got_n = 0;
    for (int c = 0; c < budget && got_n < n; c++) begin
      #1;
      if (valid[f] && ready[f]) begin
        got_d[got_n]  = data[f];
        got_l[got_n]  = last[f];
        got_fc[got_n] = fcv(f);
        got_n++;
      end
      @(negedge clk);
    end
    chk($sformatf("collect%0d_count", f), got_n, n);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    int holdbad;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'h13, 1'b0, 16'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'h14, 1'b1, 16'd0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 16'd1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h16, 1'b0, 16'd1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'h17, 1'b0, 16'd1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h18, 1'b1, 16'd1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd2};

    for (int i = 0; i < 3; i++) ready[i] = 1'b1;

    // Reset hold with a non-empty FIFO
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) push(0, 8'h11 + 8'(i));
    #1;
    chk("rst_rinc", rinc[0], 1'b0);
    chk("rst_valid", valid[0], 1'b0);
    chk("rst_fc", fc0, 16'd0);
    chk("rst_data", data[0], 8'h00);
    @(negedge clk);
    #1;
    chk("rst_rinc_held", rinc[0], 1'b0);

    // Release and stream 8 words, one row per cycle
    @(negedge clk);
    rrst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      ready[0] = tbl[i].ready;
      #1;
      chk($sformatf("row%0d_rinc", i), rinc[0], tbl[i].rinc);
      chk($sformatf("row%0d_valid", i), valid[0], tbl[i].valid);
      if (tbl[i].valid) chk($sformatf("row%0d_data", i), data[0], tbl[i].data);
      chk($sformatf("row%0d_last", i), last[0], tbl[i].last);
      chk($sformatf("row%0d_fc", i), fc0, tbl[i].fc);
    end

    // Backpressure: 6 words queued, downstream stalled
    @(negedge clk);
    ready[0] = 1'b0;
    for (int i = 0; i < 6; i++) push(0, 8'h21 + 8'(i));
    pulses = 0;
    holdbad = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (rinc[0]) pulses++;
      if (c > 0 && !(valid[0] === 1'b1 && data[0] === 8'h21)) holdbad++;
    end
    chk("bp_rinc_pulses", pulses, 2);
    chk("bp_hold_bad_cycles", holdbad, 0);
    chk("bp_rinc_full", rinc[0], 1'b0);
    @(negedge clk);
    ready[0] = 1'b1;
    collect(0, 6, 30);
    for (int i = 0; i < got_n; i++) begin
      chk($sformatf("bp_beat%0d_data", i), got_d[i], 8'h21 + 8'(i));
      chk($sformatf("bp_beat%0d_last", i), got_l[i], (i == 3));
    end
    #1;
    chk("bp_fc", fc0, 16'd3);

    // Reset mid-frame (two beats into the next frame), then a frame with a long gap
    rrst_n = 1'b0;
    #1;
    chk("mid_rst_valid", valid[0], 1'b0);
    chk("mid_rst_fc", fc0, 16'd0);
    @(negedge clk);
    rrst_n = 1'b1;
    for (int i = 0; i < 3; i++) push(0, 8'h31 + 8'(i));
    collect(0, 3, 20);
    for (int i = 0; i < got_n; i++) begin
      chk($sformatf("part_beat%0d_data", i), got_d[i], 8'h31 + 8'(i));
      chk($sformatf("part_beat%0d_last", i), got_l[i], 1'b0);
    end
    repeat (50) @(negedge clk);
    #1;
    chk("gap_valid", valid[0], 1'b0);
    chk("gap_rinc", rinc[0], 1'b0);
    chk("gap_fc", fc0, 16'd0);
    @(negedge clk);
    push(0, 8'h34);
    collect(0, 1, 10);
    if (got_n > 0) begin
      chk("part_beat3_data", got_d[0], 8'h34);
      chk("part_beat3_last", got_l[0], 1'b1);
    end
    #1;
    chk("part_fc", fc0, 16'd1);

    // Frame counter wrap with CW=2
    @(negedge clk);
    for (int i = 0; i < 20; i++) push(1, 8'h40 + 8'(i));
    collect(1, 20, 60);
    for (int k = 1; k <= 4 && 4 * k < got_n; k++)
      chk($sformatf("wrap_fc_frame%0d", k), got_fc[4 * k], (k % 4));
    for (int i = 0; i < got_n; i++)
      chk($sformatf("wrap_beat%0d_last", i), got_l[i], ((i % 4) == 3));
    #1;
    chk("wrap_fc_final", fc1, 2'd1);

    // PKT_LEN=1: every beat is last
    @(negedge clk);
    for (int i = 0; i < 5; i++) push(2, 8'h50 + 8'(i));
    collect(2, 5, 30);
    for (int i = 0; i < got_n; i++) begin
      chk($sformatf("p1_beat%0d_data", i), got_d[i], 8'h50 + 8'(i));
      chk($sformatf("p1_beat%0d_last", i), got_l[i], 1'b1);
    end
    #1;
    chk("p1_fc", fc2, 16'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
